// File: rtl/wb_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_writer_pkg
// Brief    : Shared widths, constants and queue-entry type for the
//            write-back stage.
// Revision : 1.0 - initial release
// ============================================================================
package wb_writer_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    // Register x0 is hard-wired; writes to it are dropped and it is never busy.
    localparam logic [AW-1:0] REG_ZERO = '0;

    // One completed instruction waiting to retire.
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            is_load;
        logic            dvalid;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Brief    : In-order circular buffer of retiring results with a head pointer
//            for retire, a tail pointer for push and an in-order fill pointer
//            that steers returning load data to the oldest waiting load.
// Revision : 1.0 - initial release
// ============================================================================
module wb_queue
    import wb_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  wb_entry_t        i_push_entry,
    input  logic             i_pop,
    input  logic             i_fill,
    input  logic [XLEN-1:0]  i_fill_data,
    output logic             o_fill_avail,
    output logic             o_ready,
    output logic             o_empty,
    output logic             o_head_ready,
    output logic [AW-1:0]    o_head_rd,
    output logic [XLEN-1:0]  o_head_data,
    output logic [DEPTH-1:0] o_valid,
    output logic [AW-1:0]    o_rd [DEPTH]
);

    localparam int                c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_full_cnt = (c_ptr_w + 1)'(DEPTH);

    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_ptr_w:0]   r_count;
    logic [DEPTH-1:0]   r_valid;
    wb_entry_t          r_mem [DEPTH];

    logic [c_ptr_w-1:0] w_fill_idx;
    logic [c_ptr_w-1:0] w_scan_idx;
    logic               w_fill_found;
    logic               w_push;
    logic               w_pop;
    logic               w_fill_do;

    assign o_ready      = (r_count < c_full_cnt);
    assign o_empty      = (r_count == '0);
    assign o_head_ready = r_valid[r_head] && r_mem[r_head].dvalid;
    assign o_head_rd    = r_mem[r_head].rd;
    assign o_head_data  = r_mem[r_head].data;
    assign o_valid      = r_valid;
    assign o_fill_avail = w_fill_found;

    // Accept only when there is room and only retire an entry that is complete.
    assign w_push    = i_push && o_ready;
    assign w_pop     = i_pop && o_head_ready;
    assign w_fill_do = i_fill && w_fill_found;

    // Fill pointer: oldest queued load still waiting for data, scanning from head.
    always_comb begin
        w_fill_idx   = r_head;
        w_scan_idx   = r_head;
        w_fill_found = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx = r_head + c_ptr_w'(k);
            if (!w_fill_found && r_valid[w_scan_idx] &&
                r_mem[w_scan_idx].is_load && !r_mem[w_scan_idx].dvalid) begin
                w_fill_found = 1'b1;
                w_fill_idx   = w_scan_idx;
            end
        end
    end

    // Pointer, occupancy and valid-bit bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_tail          <= r_tail + 1'b1;
                r_valid[r_tail] <= 1'b1;
            end
            if (w_pop) begin
                r_head          <= r_head + 1'b1;
                r_valid[r_head] <= 1'b0;
            end
            r_count <= r_count + {{c_ptr_w{1'b0}}, w_push} - {{c_ptr_w{1'b0}}, w_pop};
        end
    end

    // Entry payload storage; a fill never targets the slot being pushed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_push_entry;
        end
        if (w_fill_do) begin
            r_mem[w_fill_idx].data   <= i_fill_data;
            r_mem[w_fill_idx].dvalid <= 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_rd_out
            assign o_rd[g] = r_mem[g].rd;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_writer.sv
`default_nettype none
// ============================================================================
// Module   : wb_writer
// Brief    : Write-back stage. Queues execute results in program order,
//            merges in-order load data, issues one register-file write per
//            retired entry and exports a busy scoreboard for hazard checks.
// Revision : 1.0 - initial release
// ============================================================================
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_is_load,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   q_rs1,
    input  logic [AW-1:0]   q_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            empty,
    output logic            rsp_err
);

    wb_entry_t        w_push_entry;
    logic             w_fill_avail;
    logic             w_q_empty;
    logic             w_head_ready;
    logic [AW-1:0]    w_head_rd;
    logic [XLEN-1:0]  w_head_data;
    logic [DEPTH-1:0] w_valid;
    logic [AW-1:0]    w_rd [DEPTH];
    logic             w_hit1;
    logic             w_hit2;

    // Loads enter with no data; their payload arrives later through the fill port.
    always_comb begin
        w_push_entry.rd      = in_rd;
        w_push_entry.data    = in_is_load ? '0 : in_data;
        w_push_entry.is_load = in_is_load;
        w_push_entry.dvalid  = !in_is_load;
    end

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .i_push       (in_valid),
        .i_push_entry (w_push_entry),
        .i_pop        (w_head_ready),
        .i_fill       (mem_rsp_valid),
        .i_fill_data  (mem_rsp_data),
        .o_fill_avail (w_fill_avail),
        .o_ready      (in_ready),
        .o_empty      (w_q_empty),
        .o_head_ready (w_head_ready),
        .o_head_rd    (w_head_rd),
        .o_head_data  (w_head_data),
        .o_valid      (w_valid),
        .o_rd         (w_rd)
    );

    // Retire register: one write per completed head entry, none for x0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (w_head_ready) begin
            wr_en   <= (w_head_rd != REG_ZERO);
            wr_addr <= w_head_rd;
            wr_data <= w_head_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Sticky flag for a load response that had no waiting load to land in.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_err <= 1'b0;
        end else if (mem_rsp_valid && !w_fill_avail) begin
            rsp_err <= 1'b1;
        end
    end

    // Scoreboard: a register is busy while queued or while its write is on the port.
    always_comb begin
        w_hit1 = wr_en && (wr_addr == q_rs1);
        w_hit2 = wr_en && (wr_addr == q_rs2);
        for (int k = 0; k < DEPTH; k++) begin
            if (w_valid[k] && (w_rd[k] == q_rs1)) w_hit1 = 1'b1;
            if (w_valid[k] && (w_rd[k] == q_rs2)) w_hit2 = 1'b1;
        end
    end

    assign rs1_busy = (q_rs1 != REG_ZERO) && w_hit1;
    assign rs2_busy = (q_rs2 != REG_ZERO) && w_hit2;
    assign empty    = w_q_empty && !wr_en;

endmodule
`default_nettype wire

// File: tb/tb_wb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_writer
// Brief    : Directed self-checking bench for the write-back stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        in_is_load;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        empty;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_writer #(.DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .in_is_load    (in_is_load),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .q_rs1         (q_rs1),
        .q_rs2         (q_rs2),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .empty         (empty),
        .rsp_err       (rsp_err)
    );

    // Advance one edge; outputs are then sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_rd = '0; in_data = '0; in_is_load = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        q_rs1 = 5'd5; q_rs2 = 5'd0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        n_tests++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_wr_bus: got %0h/%0h expected 0/0", wr_addr, wr_data); end
        n_tests++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b%b expected 00", rs1_busy, rs2_busy); end
        n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    endtask

    task automatic test_alu();
        q_rs1 = 5'd5;
        in_valid = 1'b1; in_rd = 5'd5; in_data = 32'h1234; in_is_load = 1'b0;
        tick();
        idle_inputs();
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL alu_early_write: got %b expected 0", wr_en); end
        n_tests++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL alu_busy_queued: got %b expected 1", rs1_busy); end
        n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL alu_not_empty: got %b expected 0", empty); end
        tick();
        n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h1234) begin n_fail++; $display("FAIL alu_write: got en=%b a=%0d d=%0h expected en=1 a=5 d=1234", wr_en, wr_addr, wr_data); end
        n_tests++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL alu_busy_writing: got %b expected 1", rs1_busy); end
        tick();
        n_tests++; if (wr_en !== 1'b0 || rs1_busy !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL alu_after: got en=%b busy=%b empty=%b expected 0 0 1", wr_en, rs1_busy, empty); end
    endtask

    task automatic test_load_order();
        q_rs1 = 5'd7; q_rs2 = 5'd8;
        in_valid = 1'b1; in_rd = 5'd7; in_data = 32'h5555; in_is_load = 1'b1;
        tick();
        in_valid = 1'b1; in_rd = 5'd8; in_data = 32'hAA; in_is_load = 1'b0;
        tick();
        idle_inputs();
        n_tests++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin n_fail++; $display("FAIL ld_busy: got %b%b expected 11", rs1_busy, rs2_busy); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL ld_bypass_wait%0d: got %b expected 0", i, wr_en); end
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL ld_fill_edge: got %b expected 0", wr_en); end
        tick();
        n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_write_load: got en=%b a=%0d d=%0h expected en=1 a=7 d=deadbeef", wr_en, wr_addr, wr_data); end
        tick();
        n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd8 || wr_data !== 32'hAA) begin n_fail++; $display("FAIL ld_write_alu: got en=%b a=%0d d=%0h expected en=1 a=8 d=aa", wr_en, wr_addr, wr_data); end
        tick();
        n_tests++; if (wr_en !== 1'b0 || empty !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL ld_drain: got en=%b empty=%b err=%b expected 0 1 0", wr_en, empty, rsp_err); end
    endtask

    task automatic test_full();
        q_rs1 = 5'd9; q_rs2 = 5'd4;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_rd = 5'(i); in_data = 32'hFFFF; in_is_load = 1'b1;
            tick();
        end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", in_ready); end
        in_valid = 1'b1; in_rd = 5'd9; in_data = 32'h99; in_is_load = 1'b0;
        tick();
        idle_inputs();
        n_tests++; if (rs1_busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_reject: got busy=%b ready=%b expected 0 0", rs1_busy, in_ready); end
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'h100 + 32'(i);
            tick();
            if (i == 0) begin
                n_tests++; if (wr_en !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_first_fill: got en=%b ready=%b expected 0 0", wr_en, in_ready); end
            end else begin
                n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== 32'h100 + 32'(i - 1) || in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL full_write%0d: got en=%b a=%0d d=%0h ready=%b expected en=1 a=%0d d=%0h ready=1", i, wr_en, wr_addr, wr_data, in_ready, i, 32'h100 + 32'(i - 1));
                end
            end
        end
        idle_inputs();
        tick();
        n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 32'h103) begin n_fail++; $display("FAIL full_write4: got en=%b a=%0d d=%0h expected en=1 a=4 d=103", wr_en, wr_addr, wr_data); end
        tick();
        n_tests++; if (wr_en !== 1'b0 || empty !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL full_drain: got en=%b empty=%b err=%b expected 0 1 0", wr_en, empty, rsp_err); end
    endtask

    task automatic test_rd_zero();
        q_rs1 = 5'd0; q_rs2 = 5'd0;
        in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFF; in_is_load = 1'b0;
        tick();
        idle_inputs();
        n_tests++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || empty !== 1'b0) begin n_fail++; $display("FAIL zero_queued: got busy=%b%b empty=%b expected 00 0", rs1_busy, rs2_busy, empty); end
        tick();
        n_tests++; if (wr_en !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL zero_retire: got en=%b empty=%b expected 0 1", wr_en, empty); end
        tick();
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL zero_after: got %b expected 0", wr_en); end
    endtask

    task automatic test_rsp_err();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77;
        tick();
        idle_inputs();
        n_tests++; if (rsp_err !== 1'b1 || wr_en !== 1'b0) begin n_fail++; $display("FAIL err_set: got err=%b en=%b expected 1 0", rsp_err, wr_en); end
        tick(); tick();
        n_tests++; if (rsp_err !== 1'b1 || wr_en !== 1'b0) begin n_fail++; $display("FAIL err_sticky: got err=%b en=%b expected 1 0", rsp_err, wr_en); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", rsp_err); end
    endtask

    task automatic test_reset_mid();
        q_rs1 = 5'd3; q_rs2 = 5'd4;
        in_valid = 1'b1; in_rd = 5'd3; in_is_load = 1'b1;
        tick();
        in_rd = 5'd4;
        tick();
        idle_inputs();
        n_tests++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b%b expected 11", rs1_busy, rs2_busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (empty !== 1'b1 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || in_ready !== 1'b1 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got empty=%b busy=%b%b ready=%b en=%b expected 1 00 1 0", empty, rs1_busy, rs2_busy, in_ready, wr_en);
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE;
        tick();
        idle_inputs();
        n_tests++; if (rsp_err !== 1'b1 || wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_late_rsp: got err=%b en=%b expected 1 0", rsp_err, wr_en); end
        tick();
        n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_no_write: got %b expected 0", wr_en); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        q_rs1 = 5'd12; q_rs2 = 5'd0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_rd = 5'(10 + i); in_data = 32'hA0 + 32'(i); in_is_load = 1'b0;
            tick();
            if (i > 0) begin
                n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'(9 + i) || wr_data !== 32'hA0 + 32'(i - 1)) begin
                    n_fail++; $display("FAIL b2b_write%0d: got en=%b a=%0d d=%0h expected en=1 a=%0d d=%0h", i - 1, wr_en, wr_addr, wr_data, 9 + i, 32'hA0 + 32'(i - 1));
                end
            end
        end
        idle_inputs();
        tick();
        n_tests++; if (wr_en !== 1'b1 || wr_addr !== 5'd12 || wr_data !== 32'hA2 || rs1_busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_write2: got en=%b a=%0d d=%0h busy=%b expected en=1 a=12 d=a2 busy=1", wr_en, wr_addr, wr_data, rs1_busy);
        end
        tick();
        n_tests++; if (wr_en !== 1'b0 || empty !== 1'b1 || rs1_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got en=%b empty=%b busy=%b expected 0 1 0", wr_en, empty, rs1_busy); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        q_rs1 = '0; q_rs2 = '0;
        test_reset();
        test_alu();
        test_load_order();
        test_full();
        test_rd_zero();
        test_rsp_err();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Write-back stage of the single-issue core.
- Accepts completed results from execute (ALU results carry data; loads carry only a destination) and keeps them in program order in a small queue.
- Merges in-order load data returned by the data-memory port and issues exactly one register-file write per retired entry (write enable, destination, data).
- Exports a per-source busy scoreboard to the decode/hazard logic.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- XLEN, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute presents a result
- in_ready  out  1  queue can accept
- in_rd  in  AW  destination register
- in_data  in  XLEN  ALU result; ignored when in_is_load=1
- in_is_load  in  1  entry waits for memory data
- mem_rsp_valid  in  1  load data returned, strictly in load-issue order
- mem_rsp_data  in  XLEN  load data
- wr_en  out  1  register-file write enable, one-cycle pulse per write
- wr_addr  out  AW  register-file destination
- wr_data  out  XLEN  register-file data
- q_rs1  in  AW  scoreboard query 1
- q_rs2  in  AW  scoreboard query 2
- rs1_busy  out  1  write to q_rs1 outstanding
- rs2_busy  out  1  write to q_rs2 outstanding
- empty  out  1  no entries queued and wr_en=0
- rsp_err  out  1  sticky: load response arrived with no load waiting

Behaviour:
- Reset (sync, active-high, clk only):
  - Queue emptied; head, tail and fill pointers = 0.
  - wr_en=0, wr_addr=0, wr_data=0, rsp_err=0.
  - Therefore in_ready=1, empty=1, rs1_busy=0, rs2_busy=0.
  - Reset mid-operation discards all queued entries and pending loads; no write issued on the reset edge.
- Entry fields: rd, data, is_load, dvalid, valid.
- Push:
  - in_valid && in_ready at an edge writes the entry at tail, then tail+1 (wraps mod DEPTH).
  - dvalid = !in_is_load.
  - in_ready = (count < DEPTH); registered count, no same-cycle pass-through when full.
- Load fill:
  - Fill pointer tracks the oldest valid entry with is_load=1 and dvalid=0.
  - mem_rsp_valid at an edge stores mem_rsp_data into that entry and sets dvalid.
  - If no such entry exists, the response is dropped and rsp_err sets; rsp_err clears only on reset.
  - An entry pushed and filled at the same edge is not possible: fills target only entries already queued.
- Retire:
  - At each edge, if head is valid and dvalid: pop head.
  - wr_en<=1 only when rd!=0.
  - wr_addr<=rd, wr_data<=data.
  - Otherwise wr_en<=0; wr_addr/wr_data hold.
  - At most one retire per cycle; retired rd=0 entries consume a cycle with no write.
- Latency:
  - ALU result accepted at edge E into an empty queue → wr_en high for the cycle after E+1.
  - Load filled at edge F while at head → wr_en high for the cycle after F+1.
- Simultaneous events:
  - Push, fill and retire may all occur at one edge.
  - count_next = count + push − pop.
  - A fill targeting the head at the same edge as head retire is impossible (head not dvalid, so no retire).
- Scoreboard:
  - rsN_busy = (q_rsN != 0) && (any valid entry with rd == q_rsN, or wr_en && wr_addr == q_rsN).
  - Combinational from registered state.
- Ordering: writes leave strictly in push order; a later ALU entry never bypasses an older unfilled load.

Decomposition:
- Shared package (e.g. core_pkg): XLEN, AW, REG_ZERO=0, and a wb_entry_t struct {rd, data, is_load, dvalid}.
- One sub-module is natural: wb_queue, a DEPTH-entry circular buffer with head/tail/fill pointers, count, and an entry-indexed fill port.
- wb_writer keeps the retire register, scoreboard compare and rsp_err.

Test Plan:
- ALU rd=5, data=0x1234 into empty queue → wr_en pulse 2 edges later with wr_addr=5, wr_data=0x1234; rs1_busy(q_rs1=5)=1 until the cycle after that pulse.
- Load rd=7, then ALU rd=8 data=0xAA; mem_rsp 0xDEADBEEF 3 cycles later → write (7, 0xDEADBEEF) precedes write (8, 0xAA); no earlier write.
- Fill to DEPTH=4 with loads → in_ready=0; a 5th in_valid is not accepted. Then 4 responses → 4 writes in order; in_ready=1 after the first retire.
- ALU rd=0 data=0xFF → no wr_en pulse; empty returns to 1; rs busy for q=0 always 0.
- mem_rsp_valid with queue empty → rsp_err=1 and stays 1; no write. Reset → rsp_err=0.
- Two loads queued, reset asserted → after the reset edge empty=1, busy=0; late mem_rsp sets rsp_err; no wr_en.
